fpga_test_sequencer: RTL

//  Synthesizable on-FPGA run controller, successor to the single-DUT reset/enable/done harness.

---
 rtl/fpga_test_sequencer_if.sv | 37 +++
 rtl/fpga_test_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fpga_test_sequencer_if.sv
// Bus bundle between the FPGA test sequencer and its host/DUT side.
// Carries the run configuration (start_i, num_runs_i, ch_mask_i), the
// per-channel DUT handshake (dut_done_i, dut_error_i, dut_reset_n_o,
// dut_enable_o) and the sticky status outputs (busy_o, done_o, error_o,
// timeout_o, err_ch_o, runs_done_o).
//   slave  : the sequencer (drives *_o, receives *_i)
//   master : host / DUT side (drives *_i, receives *_o)
interface fpga_test_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int RUNS_W = 8
);
    logic              start_i;
    logic [RUNS_W-1:0] num_runs_i;
    logic [NUM_CH-1:0] ch_mask_i;
    logic [NUM_CH-1:0] dut_done_i;
    logic [NUM_CH-1:0] dut_error_i;
    logic [NUM_CH-1:0] dut_reset_n_o;
    logic [NUM_CH-1:0] dut_enable_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic              timeout_o;
    logic [NUM_CH-1:0] err_ch_o;
    logic [RUNS_W-1:0] runs_done_o;

    modport slave (
        input  start_i, num_runs_i, ch_mask_i, dut_done_i, dut_error_i,
        output dut_reset_n_o, dut_enable_o, busy_o, done_o, error_o,
               timeout_o, err_ch_o, runs_done_o
    );

    modport master (
        output start_i, num_runs_i, ch_mask_i, dut_done_i, dut_error_i,
        input  dut_reset_n_o, dut_enable_o, busy_o, done_o, error_o,
               timeout_o, err_ch_o, runs_done_o
    );
endinterface

// File: rtl/fpga_test_sequencer.sv
// On-FPGA run controller: pulses reset, then enables the masked DUT channels,
// collects per-channel done/error, and repeats for num_runs runs with a
// per-run watchdog. Aggregate status is sticky until the next accepted start.
// Ports:
//   clk_i      system clock
//   reset_n_i  synchronous active-low reset
//   bus        fpga_test_sequencer_if.slave (config, DUT handshake, status)
// Optional build macro: STOP_ON_ERROR_EN -- the first masked DUT error ends the
// sequence (FIN next cycle, run not counted). Undefined: errors are only
// recorded and every run continues to completion or timeout.
//
// state | meaning
// IDLE  | after reset, waiting for start_i
// RST   | masked DUT channels held in reset for RST_CYC cycles
// RUN   | masked channels enabled, collecting done/error, watchdog running
// GAP   | one idle cycle between runs, decides next run or finish
// FIN   | sequence finished, status held until start_i or reset
module fpga_test_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int RUNS_W      = 8,
    parameter int TIMEOUT_W   = 24,
    parameter int TIMEOUT_CYC = 2**24 - 1,
    parameter int RST_CYC     = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    fpga_test_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RST_W-1:0]     RST_LOAD = RST_W'(RST_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [RUNS_W-1:0]    RUNS_MAX = '1;

    logic [2:0]           state,     state_n;
    logic [NUM_CH-1:0]    mask_q,    mask_n;
    logic [RUNS_W-1:0]    runs_q,    runs_n;
    logic [RST_W-1:0]     rst_cnt,   rst_cnt_n;
    logic [TIMEOUT_W-1:0] wd_cnt,    wd_cnt_n;
    logic [NUM_CH-1:0]    done_lat,  done_lat_n;
    logic [NUM_CH-1:0]    err_ch_q,  err_ch_n;
    logic                 timeout_q, timeout_n;
    logic                 error_q,   error_n;
    logic [RUNS_W-1:0]    runs_done, runs_done_n;

    logic [NUM_CH-1:0]    done_hit;
    logic [NUM_CH-1:0]    err_hit;
    logic                 all_done;
    logic                 start_ok;
    logic                 stop_err;

    always_comb begin
        state_n     = state;
        mask_n      = mask_q;
        runs_n      = runs_q;
        rst_cnt_n   = rst_cnt;
        wd_cnt_n    = wd_cnt;
        done_lat_n  = done_lat;
        err_ch_n    = err_ch_q;
        timeout_n   = timeout_q;
        runs_done_n = runs_done;

        start_ok = bus.start_i && ((state == S_IDLE) || (state == S_FIN));
        // Completion looks at this cycle's done too, so the last done seen at
        // an edge moves straight to GAP.
        done_hit = done_lat | (bus.dut_done_i & mask_q);
        all_done = &(done_hit | ~mask_q);
        err_hit  = bus.dut_error_i & mask_q;
`ifdef STOP_ON_ERROR_EN
        stop_err = |err_hit;
`else
        stop_err = 1'b0;
`endif

        case (state)
            S_IDLE, S_FIN: begin
                if (start_ok) begin
                    mask_n      = bus.ch_mask_i;
                    runs_n      = bus.num_runs_i;
                    err_ch_n    = '0;
                    timeout_n   = 1'b0;
                    runs_done_n = '0;
                    done_lat_n  = '0;
                    wd_cnt_n    = '0;
                    if ((bus.ch_mask_i == '0) || (bus.num_runs_i == '0)) begin
                        state_n = S_FIN;
                    end else begin
                        state_n   = S_RST;
                        rst_cnt_n = RST_LOAD;
                    end
                end
            end
            S_RST: begin
                if (rst_cnt == '0) begin
                    state_n  = S_RUN;
                    wd_cnt_n = '0;
                end else begin
                    rst_cnt_n = rst_cnt - RST_W'(1);
                end
            end
            S_RUN: begin
                done_lat_n = done_hit;
                err_ch_n   = err_ch_q | err_hit;
                wd_cnt_n   = wd_cnt + TIMEOUT_W'(1);
                if (stop_err) begin
                    state_n = S_FIN;
                end else if (all_done) begin
                    if (runs_done != RUNS_MAX) begin
                        runs_done_n = runs_done + RUNS_W'(1);
                    end
                    state_n = S_GAP;
                end else if (wd_cnt == WD_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = S_FIN;
                end
            end
            S_GAP: begin
                done_lat_n = '0;
                if (runs_done == runs_q) begin
                    state_n = S_FIN;
                end else begin
                    state_n   = S_RST;
                    rst_cnt_n = RST_LOAD;
                end
            end
            default: state_n = S_IDLE;
        endcase

        error_n = (|err_ch_n) | timeout_n;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state     <= S_IDLE;
            mask_q    <= '0;
            runs_q    <= '0;
            rst_cnt   <= '0;
            wd_cnt    <= '0;
            done_lat  <= '0;
            err_ch_q  <= '0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            runs_done <= '0;
        end else begin
            state     <= state_n;
            mask_q    <= mask_n;
            runs_q    <= runs_n;
            rst_cnt   <= rst_cnt_n;
            wd_cnt    <= wd_cnt_n;
            done_lat  <= done_lat_n;
            err_ch_q  <= err_ch_n;
            timeout_q <= timeout_n;
            error_q   <= error_n;
            runs_done <= runs_done_n;
        end
    end

    assign bus.dut_reset_n_o = (state == S_RST) ? ~mask_q : '1;
    assign bus.dut_enable_o  = (state == S_RUN) ? mask_q : '0;
    assign bus.busy_o        = (state == S_RST) || (state == S_RUN) || (state == S_GAP);
    assign bus.done_o        = (state == S_FIN);
    assign bus.error_o       = error_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.err_ch_o      = err_ch_q;
    assign bus.runs_done_o   = runs_done;
endmodule
